note_sequencer: RTL and testbench

- Plays a short melody on the square-wave tone generator.
- Steps through a small note table. For each note it drives the tone generator's half-period and gate, and times note duration in audio sample ticks.
- Sits between the control/host logic (table load, start/stop) and the tone generator; shares its sample-rate enable.

---
 rtl/note_sequencer_if.sv | 28 ++
 rtl/note_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_note_sequencer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/note_sequencer_if.sv
// rtl/note_sequencer_if.sv - host/tone-generator bus for the note sequencer
interface note_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int HP_W   = 12,
    parameter int DUR_W  = 12
);
    logic                    sample_tick;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [HP_W+DUR_W-1:0]   wr_data;
    logic                    start;
    logic                    stop;
    logic [HP_W-1:0]         tone_half_period;
    logic                    tone_en;
    logic [ADDR_W-1:0]       note_idx;
    logic                    busy;
    logic                    done;

    modport master (
        output sample_tick, wr_en, wr_addr, wr_data, start, stop,
        input  tone_half_period, tone_en, note_idx, busy, done
    );

    modport slave (
        input  sample_tick, wr_en, wr_addr, wr_data, start, stop,
        output tone_half_period, tone_en, note_idx, busy, done
    );
endinterface

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - note-table melody sequencer; NOTE_SEQ_LOOP_EN makes playback repeat
module note_sequencer #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int HP_W        = 12,
    parameter int DUR_W       = 12,
    parameter int GAP_SAMPLES = 480
) (
    input  logic             clk,
    input  logic             reset,
    note_sequencer_if.slave  bus
);
    localparam int WORD_W = HP_W + DUR_W;
    localparam int GAP_W  = (GAP_SAMPLES > 0) ? $clog2(GAP_SAMPLES + 1) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_PLAY,
        S_GAP,
        S_ADVANCE,
        S_FINISH
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [WORD_W-1:0]   r_mem [DEPTH];
    logic [WORD_W-1:0]   r_rd_data;
    logic [DUR_W-1:0]    r_dur_cnt, w_dur_cnt_nxt;
    logic [GAP_W-1:0]    r_gap_cnt, w_gap_cnt_nxt;
    logic [HP_W-1:0]     r_hp, w_hp_nxt;
    logic                r_tone_en, w_tone_en_nxt;
    logic [ADDR_W-1:0]   r_idx, w_idx_nxt;
    logic                r_done, w_done_nxt;
`ifdef NOTE_SEQ_LOOP_EN
    logic                r_empty, w_empty_nxt;
`endif

    logic [HP_W-1:0]     w_rd_hp;
    logic [DUR_W-1:0]    w_rd_dur;

    assign w_rd_hp  = r_rd_data[WORD_W-1:DUR_W];
    assign w_rd_dur = r_rd_data[DUR_W-1:0];

    // Note table: host writes only while idle, sequencer reads with one cycle latency from FETCH
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && bus.wr_en) begin
            r_mem[bus.wr_addr] <= bus.wr_data;
        end
        if (r_state == S_FETCH) begin
            r_rd_data <= r_mem[r_idx];
        end
    end

    // Next-state and next-output logic; stop overrides everything outside IDLE
    always_comb begin
        w_state_nxt   = r_state;
        w_dur_cnt_nxt = r_dur_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_hp_nxt      = r_hp;
        w_tone_en_nxt = r_tone_en;
        w_idx_nxt     = r_idx;
        w_done_nxt    = 1'b0;
`ifdef NOTE_SEQ_LOOP_EN
        w_empty_nxt   = r_empty;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    w_state_nxt = S_FETCH;
                    w_idx_nxt   = '0;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (w_rd_dur == '0) begin
                    w_state_nxt   = S_FINISH;
                    w_hp_nxt      = '0;
                    w_tone_en_nxt = 1'b0;
                    w_done_nxt    = 1'b1;
`ifdef NOTE_SEQ_LOOP_EN
                    w_empty_nxt   = (r_idx == '0);
`endif
                end else begin
                    w_state_nxt   = S_PLAY;
                    w_dur_cnt_nxt = w_rd_dur;
                    w_hp_nxt      = w_rd_hp;
                    w_tone_en_nxt = (w_rd_hp != '0);
                end
            end
            S_PLAY: begin
                if (bus.sample_tick && r_dur_cnt != '0) begin
                    if (r_dur_cnt == DUR_W'(1)) begin
                        w_dur_cnt_nxt = '0;
                        w_tone_en_nxt = 1'b0;
                        if (GAP_SAMPLES > 0) begin
                            w_state_nxt   = S_GAP;
                            w_gap_cnt_nxt = GAP_W'(GAP_SAMPLES);
                        end else begin
                            w_state_nxt   = S_ADVANCE;
                        end
                    end else begin
                        w_dur_cnt_nxt = r_dur_cnt - DUR_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (bus.sample_tick && r_gap_cnt != '0) begin
                    if (r_gap_cnt == GAP_W'(1)) begin
                        w_gap_cnt_nxt = '0;
                        w_state_nxt   = S_ADVANCE;
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
                    end
                end
            end
            S_ADVANCE: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt   = S_FINISH;
                    w_hp_nxt      = '0;
                    w_tone_en_nxt = 1'b0;
                    w_done_nxt    = 1'b1;
`ifdef NOTE_SEQ_LOOP_EN
                    w_empty_nxt   = 1'b0;
`endif
                end else begin
                    w_state_nxt = S_FETCH;
                    w_idx_nxt   = r_idx + ADDR_W'(1);
                end
            end
            S_FINISH: begin
`ifdef NOTE_SEQ_LOOP_EN
                // An end marker in entry 0 would spin forever without playing anything
                if (r_empty) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_FETCH;
                    w_idx_nxt   = '0;
                end
`else
                w_state_nxt = S_IDLE;
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (r_state != S_IDLE && bus.stop) begin
            w_state_nxt   = S_IDLE;
            w_tone_en_nxt = 1'b0;
            w_hp_nxt      = '0;
            w_idx_nxt     = '0;
            w_done_nxt    = 1'b0;
            w_dur_cnt_nxt = '0;
            w_gap_cnt_nxt = '0;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_dur_cnt <= '0;
            r_gap_cnt <= '0;
            r_hp      <= '0;
            r_tone_en <= 1'b0;
            r_idx     <= '0;
            r_done    <= 1'b0;
`ifdef NOTE_SEQ_LOOP_EN
            r_empty   <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_dur_cnt <= w_dur_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_hp      <= w_hp_nxt;
            r_tone_en <= w_tone_en_nxt;
            r_idx     <= w_idx_nxt;
            r_done    <= w_done_nxt;
`ifdef NOTE_SEQ_LOOP_EN
            r_empty   <= w_empty_nxt;
`endif
        end
    end

    assign bus.tone_half_period = r_hp;
    assign bus.tone_en          = r_tone_en;
    assign bus.note_idx         = r_idx;
    assign bus.busy             = (r_state != S_IDLE);
    assign bus.done             = r_done;
endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - self-checking bench for note_sequencer against a timeline model
`timescale 1ns/1ps
module tb_note_sequencer;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int HP_W   = 12;
    localparam int DUR_W  = 12;
    localparam int WORD_W = HP_W + DUR_W;
    localparam int HMAX   = 2048;
`ifdef NOTE_SEQ_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    typedef struct packed {
        logic              busy;
        logic              done;
        logic              en;
        logic [HP_W-1:0]   hp;
        logic [ADDR_W-1:0] idx;
        logic              chk;
    } obs_t;

    logic              clk        = 1'b0;
    logic              reset      = 1'b1;
    logic              tb_tick    = 1'b0;
    logic              tb_wr_en   = 1'b0;
    logic              tb_start   = 1'b0;
    logic              tb_stop    = 1'b0;
    logic [ADDR_W-1:0] tb_wr_addr = '0;
    logic [WORD_W-1:0] tb_wr_data = '0;

    always #5 clk = ~clk;

    note_sequencer_if #(.ADDR_W(ADDR_W), .HP_W(HP_W), .DUR_W(DUR_W)) if_g ();
    note_sequencer_if #(.ADDR_W(ADDR_W), .HP_W(HP_W), .DUR_W(DUR_W)) if_z ();

    assign if_g.sample_tick = tb_tick;
    assign if_g.wr_en       = tb_wr_en;
    assign if_g.wr_addr     = tb_wr_addr;
    assign if_g.wr_data     = tb_wr_data;
    assign if_g.start       = tb_start;
    assign if_g.stop        = tb_stop;
    assign if_z.sample_tick = tb_tick;
    assign if_z.wr_en       = tb_wr_en;
    assign if_z.wr_addr     = tb_wr_addr;
    assign if_z.wr_data     = tb_wr_data;
    assign if_z.start       = tb_start;
    assign if_z.stop        = tb_stop;

    note_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HP_W(HP_W), .DUR_W(DUR_W), .GAP_SAMPLES(1))
        dut_g (.clk(clk), .reset(reset), .bus(if_g.slave));
    note_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HP_W(HP_W), .DUR_W(DUR_W), .GAP_SAMPLES(0))
        dut_z (.clk(clk), .reset(reset), .bus(if_z.slave));

    int n_tests = 0;
    int n_fail  = 0;

    logic [WORD_W-1:0] tbl [DEPTH];
    bit                tk [HMAX];
    obs_t              exp_t [2][HMAX];
    int                exp_len [2];
    bit                exp_busy_end [2];

    function automatic logic [WORD_W-1:0] mk(input int hp, input int dur);
        return {HP_W'(hp), DUR_W'(dur)};
    endfunction

    function automatic obs_t observe(input int d, input logic chk);
        obs_t o;
        if (d == 0) begin
            o.busy = if_g.busy; o.done = if_g.done; o.en = if_g.tone_en;
            o.hp = if_g.tone_half_period; o.idx = chk ? if_g.note_idx : '0;
        end else begin
            o.busy = if_z.busy; o.done = if_z.done; o.en = if_z.tone_en;
            o.hp = if_z.tone_half_period; o.idx = chk ? if_z.note_idx : '0;
        end
        o.chk = chk;
        return o;
    endfunction

    // Cycle of the n-th sample tick at or after cycle 'from'
    function automatic int nth_tick(input int from, input int n);
        int seen = 0;
        for (int c = from; c < HMAX; c++) begin
            if (tk[c]) begin
                seen++;
                if (seen == n) return c;
            end
        end
        return HMAX;
    endfunction

    function automatic void put(input int d, input int c, input bit busy, input bit done,
                                input bit en, input logic [HP_W-1:0] hp, input int idx);
        if (c >= 0 && c < HMAX) begin
            exp_t[d][c].busy = busy; exp_t[d][c].done = done; exp_t[d][c].en = en;
            exp_t[d][c].hp = hp; exp_t[d][c].idx = ADDR_W'(idx); exp_t[d][c].chk = 1'b1;
        end
    endfunction

    // Expected outputs per cycle after start (cycle 0 = start cycle): each note costs a fetch
    // and a decode cycle, then plays for 'dur' ticks, then the gap, then one advance cycle.
    function automatic void build(input int d, input int gap, input int horizon);
        int t = 1;
        int i = 0;
        int p, e, q, fin, dur;
        bit marker0;
        logic [HP_W-1:0] hp = '0;
        logic [HP_W-1:0] h;
        for (int k = 0; k < HMAX; k++) exp_t[d][k] = '0;
        exp_len[d] = horizon;
        exp_busy_end[d] = 1'b1;
        while (t < horizon) begin
            put(d, t, 1, 0, 0, hp, i);
            put(d, t + 1, 1, 0, 0, hp, i);
            h   = tbl[i][WORD_W-1:DUR_W];
            dur = int'(tbl[i][DUR_W-1:0]);
            if (dur == 0) begin
                fin = t + 2;
                marker0 = (i == 0);
            end else begin
                p = t + 2;
                e = nth_tick(p, dur);
                for (int c = p; c <= e && c < HMAX; c++) put(d, c, 1, 0, (h != 0), h, i);
                hp = h;
                q = e + 1;
                if (gap > 0) begin
                    e = nth_tick(q, gap);
                    for (int c = q; c <= e && c < HMAX; c++) put(d, c, 1, 0, 0, hp, i);
                    q = e + 1;
                end
                put(d, q, 1, 0, 0, hp, i);
                if (i < DEPTH - 1) begin
                    i++;
                    t = q + 1;
                    continue;
                end
                fin = q + 1;
                marker0 = 1'b0;
            end
            put(d, fin, 1, 1, 0, '0, i);
            hp = '0;
            if (LOOP_EN && !marker0) begin
                i = 0;
                t = fin + 1;
            end else begin
                exp_len[d] = (fin + 4 < horizon) ? fin + 4 : horizon;
                exp_busy_end[d] = (fin + 1 >= horizon);
                return;
            end
        end
    endfunction

    task automatic set_ticks_periodic(input int per);
        for (int c = 0; c < HMAX; c++) tk[c] = ((c % per) == per - 1);
    endtask

    task automatic set_ticks_random(input int pct);
        for (int c = 0; c < HMAX; c++) tk[c] = ($urandom_range(0, 99) < pct);
    endtask

    task automatic random_table();
        for (int i = 0; i < DEPTH; i++) begin
            tbl[i] = mk(($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 4095),
                        ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 5));
        end
    endtask

    task automatic load_table();
        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clk); #1;
            tb_wr_en = 1'b1; tb_wr_addr = ADDR_W'(i); tb_wr_data = tbl[i];
        end
        @(posedge clk); #1;
        tb_wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        @(negedge clk);
        while ((if_g.busy || if_z.busy) && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (if_g.busy || if_z.busy) begin
            n_fail++;
            $display("FAIL %s idle_wait: busy gap1=%b gap0=%b, expected 0 0", name, if_g.busy, if_z.busy);
        end
    endtask

    task automatic run_seq(input string name, input int horizon, input int wr_cycle);
        int len;
        obs_t o, e;
        build(0, 1, horizon);
        build(1, 0, horizon);
        len = (exp_len[0] > exp_len[1]) ? exp_len[0] : exp_len[1];
        for (int t = 0; t < len; t++) begin
            @(posedge clk); #1;
            tb_start   = (t == 0);
            tb_tick    = tk[t];
            tb_wr_en   = (t == wr_cycle);
            tb_wr_addr = '0;
            tb_wr_data = ~tbl[0];
            @(negedge clk);
            if (t >= 1) begin
                for (int d = 0; d < 2; d++) begin
                    if (t < exp_len[d]) begin
                        e = exp_t[d][t];
                        o = observe(d, e.chk);
                        n_tests++;
                        if (o !== e) begin
                            n_fail++;
                            $display("FAIL %s gap%0d cycle %0d: got busy=%b done=%b en=%b hp=%0d idx=%0d, expected busy=%b done=%b en=%b hp=%0d idx=%0d",
                                     name, 1 - d, t, o.busy, o.done, o.en, o.hp, o.idx,
                                     e.busy, e.done, e.en, e.hp, e.idx);
                        end
                    end
                end
            end
        end
        @(posedge clk); #1;
        tb_start = 1'b0; tb_tick = 1'b0; tb_wr_en = 1'b0;
        if (exp_busy_end[0] || exp_busy_end[1]) begin
            tb_stop = 1'b1;
            @(posedge clk); #1;
            tb_stop = 1'b0;
        end
        wait_idle(name);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (observe(d, 1'b1) !== obs_t'(1)) begin
                n_fail++;
                $display("FAIL reset gap%0d: got %h, expected all-zero outputs", 1 - d, observe(d, 1'b1));
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_plan_melody();
        random_table();
        tbl[0] = mk(54, 4); tbl[1] = mk(0, 2); tbl[2] = mk(27, 3); tbl[3] = mk(12'h5a5, 0);
        load_table();
        set_ticks_periodic(4);
        run_seq("plan_melody", 600, -1);
    endtask

    task automatic test_full_walk();
        for (int i = 0; i < DEPTH; i++) tbl[i] = mk($urandom_range(1, 4095), 1);
        load_table();
        set_ticks_periodic(3);
        run_seq("full_walk", 600, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            random_table();
            load_table();
            set_ticks_random(20 + 10 * n);
            run_seq("random", 1500, -1);
        end
    endtask

    task automatic test_stop();
        int k = 1;
        bit found = 1'b0;
        for (int i = 0; i < DEPTH; i++) tbl[i] = mk($urandom_range(1, 4095), $urandom_range(3, 6));
        tbl[8] = mk(7, 0);
        load_table();
        set_ticks_periodic(3);
        @(posedge clk); #1;
        tb_start = 1'b1; tb_tick = tk[0];
        @(negedge clk);
        while (!found && k < 1000) begin
            @(posedge clk); #1;
            tb_start = 1'b0; tb_tick = tk[k]; k++;
            @(negedge clk);
            if (if_g.busy && if_g.tone_en && if_g.note_idx == ADDR_W'(2)) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL stop_reach: got found=0, expected entry 2 playing within 1000 cycles");
        end
        @(posedge clk); #1;
        tb_tick = 1'b0; tb_stop = 1'b1; tb_start = 1'b1;
        @(posedge clk); #1;
        tb_stop = 1'b0; tb_start = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (observe(d, 1'b1) !== obs_t'(1)) begin
                n_fail++;
                $display("FAIL stop_outputs gap%0d: got %h, expected all-zero outputs", 1 - d, observe(d, 1'b1));
            end
        end
        run_seq("stop_replay", 1500, -1);
    endtask

    task automatic test_write_busy();
        random_table();
        for (int i = 0; i < 6; i++) tbl[i] = mk($urandom_range(1, 4095), $urandom_range(2, 4));
        load_table();
        set_ticks_periodic(2);
        run_seq("write_busy", 1500, 5);
        run_seq("write_busy_replay", 1500, -1);
        @(posedge clk); #1;
        tb_start = 1'b1; tb_stop = 1'b1;
        @(posedge clk); #1;
        tb_start = 1'b0; tb_stop = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_tests++;
            if (if_g.busy !== 1'b0 || if_z.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL start_stop_idle: got busy gap1=%b gap0=%b, expected 0 0", if_g.busy, if_z.busy);
            end
        end
    endtask

    task automatic test_reset_gap();
        int k = 1;
        bit seen_en = 1'b0;
        bit found = 1'b0;
        int dones = 0;
        random_table();
        tbl[0] = mk(54, 4); tbl[1] = mk(27, 3); tbl[2] = mk(0, 0);
        load_table();
        set_ticks_periodic(4);
        @(posedge clk); #1;
        tb_start = 1'b1; tb_tick = tk[0];
        @(negedge clk);
        while (!found && k < 500) begin
            @(posedge clk); #1;
            tb_start = 1'b0; tb_tick = tk[k]; k++;
            @(negedge clk);
            if (if_g.tone_en) seen_en = 1'b1;
            else if (seen_en && if_g.busy) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL reset_gap_reach: got found=0, expected gap within 500 cycles");
        end
        @(posedge clk); #1;
        tb_tick = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (observe(d, 1'b1) !== obs_t'(1)) begin
                n_fail++;
                $display("FAIL reset_gap gap%0d: got %h, expected all-zero outputs", 1 - d, observe(d, 1'b1));
            end
        end
        repeat (8) begin
            @(negedge clk);
            if (if_g.done || if_z.done || if_g.busy || if_z.busy) dones++;
        end
        n_tests++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL reset_gap_quiet: got %0d active cycles, expected 0", dones);
        end
        run_seq("reset_gap_replay", 600, -1);
    endtask

    task automatic test_loop();
        random_table();
        tbl[0] = mk(54, 2); tbl[1] = mk(99, 0);
        load_table();
        set_ticks_periodic(4);
        run_seq("loop_passes", 120, -1);
        tbl[0] = mk(33, 0);
        load_table();
        run_seq("loop_empty", 40, -1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_plan_melody();
        test_full_walk();
        test_random();
        test_stop();
        test_write_busy();
        test_reset_gap();
        test_loop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
